systolic_output_collector: RTL and testbench
============================================

Name: systolic_output_collector

Overview:
- Consumer of the systolic array's column outputs. Column j of result vector k leaves the array one cycle later than column j-1, so each vector arrives as a skewed diagonal.
- This block deskews the columns and reassembles each result vector into one aligned row.
- It writes each row into the output buffer memory at consecutive addresses, then signals completion.
- It sits between the array's column outputs and the output buffer memory. The array controller starts it.

Parameters:
- WIDTH, 8, bit width of each result element
- COL, 4, number of array columns (elements per result vector)
- LAT, 4, cycles from the start_i sample edge to the edge that samples column 0 of vector 0 (must be ≥1)
- AW, 8, output buffer address width; at most 2^AW vectors per job

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle job start pulse
- num_vec_i  in  AW+1  number of result vectors in the job (0 to 2^AW), sampled with start_i
- base_addr_i  in  AW  first output buffer address, sampled with start_i
- array_data_i  in  COL*WIDTH  packed [COL-1:0][WIDTH-1:0] skewed column outputs from the array
- ob_mem_we_o  out  1  output buffer write enable
- ob_mem_addr_o  out  AW  output buffer write address
- ob_mem_data_o  out  COL*WIDTH  packed [COL-1:0][WIDTH-1:0] aligned result vector
- busy_o  out  1  high while a job is active
- done_o  out  1  single-cycle pulse at job end

Behaviour:
- Reset (async, rstn_i low): state IDLE; all counters cleared; all deskew registers zero. Outputs are zero: ob_mem_we_o, ob_mem_addr_o, ob_mem_data_o, busy_o, done_o.
  - Reset mid-job aborts the job. No further writes occur and done_o does not pulse.
- Cycle numbering: cycle 0 is the edge where start_i=1 is sampled in IDLE. num_vec_i and base_addr_i are latched at that edge.
- Sampling: column j of vector k is sampled from array_data_i[j] at edge LAT+k+j, for k = 0..N-1.
- Deskew: column j passes through COL-1-j register stages. Column COL-1 has zero stages.
  - All columns of vector k are aligned at edge LAT+k+COL-1.
- Write for vector k is registered:
  - ob_mem_we_o=1 in the cycle following edge LAT+k+COL-1.
  - ob_mem_addr_o = (base_addr_i + k) mod 2^AW. Address wraps silently.
  - ob_mem_data_o[j] = column j of vector k.
- Writes for consecutive vectors occur on consecutive cycles. There are no gaps and no backpressure; the memory always accepts.
- When ob_mem_we_o=0, ob_mem_data_o and ob_mem_addr_o hold their last values.
- States:
  - IDLE: busy_o=0. start_i → WAIT, or → FIN if num_vec_i=0.
  - WAIT: counts LAT-1 cycles, then → COLLECT.
  - COLLECT: samples for N+COL-1 cycles, with a per-column valid window. Column j is captured only for k in 0..N-1; samples outside the window are ignored. Then → FIN.
  - FIN: done_o=1 for exactly one cycle, coincident with the cycle after the last write's we pulse. Then → IDLE.
- busy_o=1 in WAIT, COLLECT and FIN.
- num_vec_i=0: no writes; done_o pulses in cycle 1; busy_o high only in cycle 1.
- start_i while busy_o=1 is ignored and does not alter the running job.
- start_i sampled in the same cycle the FSM returns to IDLE (the cycle after done_o) is accepted.
- Back-to-back jobs therefore have a minimum spacing of one idle cycle.
- N = 2^AW is legal: all addresses are written once, the last being base_addr_i-1 mod 2^AW.
- Element values pass through unmodified. No arithmetic is performed on data.

Test Plan:
1. Defaults, base=0x10, N=1. Drive column j at cycle 4+j with value 0xA0+j, and 0xFF at all other cycles → exactly one write at addr 0x10, data {A3,A2,A1,A0}. we in cycle 8; done_o in cycle 9.
2. N=3, base=0. Column j of vector k at cycle 4+k+j = 16k+j → writes in cycles 8, 9, 10 at addrs 0, 1, 2, data {3,2,1,0}, {13,12,11,10}, {23,22,21,20}. done_o in cycle 11. Garbage outside the windows is never written.
3. N=0 → no ob_mem_we_o; done_o=1 in cycle 1 only; busy_o=1 in cycle 1 only.
4. base=0xFE, N=4 → addresses 0xFE, 0xFF, 0x00, 0x01 written in order.
5. N=5: pulse start_i again at cycle 6 → ignored; exactly 5 writes. A new start in the cycle after done_o → accepted; its first write occurs 8 cycles later.
6. N=4: assert rstn_i low at cycle 9 (after 1 write) → all outputs 0 immediately. No further writes and no done_o after reset release. A fresh N=1 job then completes correctly.

Source files
------------

// File: rtl/systolic_output_collector.sv
// Deskews the skewed column outputs of the systolic array and writes each aligned
// result vector to the output buffer at consecutive addresses.
module systolic_output_collector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COL   = 4,
  parameter int unsigned LAT   = 4,
  parameter int unsigned AW    = 8
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            start_i,
  input  logic [AW:0]                     num_vec_i,
  input  logic [AW-1:0]                   base_addr_i,
  input  logic [COL-1:0][WIDTH-1:0]       array_data_i,
  output logic                            ob_mem_we_o,
  output logic [AW-1:0]                   ob_mem_addr_o,
  output logic [COL-1:0][WIDTH-1:0]       ob_mem_data_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned CW = AW + $clog2(COL) + 2;
  localparam int unsigned WW = (LAT > 2) ? $clog2(LAT) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StCollect = 2'd2;
  localparam logic [1:0] StFin     = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [WW-1:0]             wcnt_q, wcnt_d;
  logic [AW:0]               n_q;
  logic [AW-1:0]             next_addr_q;
  logic                      we_q;
  logic [AW-1:0]             addr_q;
  logic [COL-1:0][WIDTH-1:0] data_q;

  logic                      collect;
  logic                      wr_en;
  logic [CW-1:0]             last_cnt;
  logic [WIDTH-1:0]          aligned [COL];

  assign collect  = (state_q == StCollect);
  // COLLECT spans N+COL cycles: the extra one lets done_o follow the last write.
  assign last_cnt = CW'(n_q) + CW'(COL) - CW'(1);
  assign wr_en    = collect && ((cnt_q - CW'(COL - 1)) < CW'(n_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d  = '0;
          wcnt_d = '0;
          if (num_vec_i == '0) begin
            state_d = StFin;
          end else if (LAT == 1) begin
            state_d = StCollect;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (wcnt_q == WW'(LAT - 2)) begin
          state_d = StCollect;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      StCollect: begin
        if (cnt_q == last_cnt) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      n_q         <= '0;
      next_addr_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      we_q    <= wr_en;
      if (state_q == StIdle && start_i) begin
        n_q         <= num_vec_i;
        next_addr_q <= base_addr_i;
      end else if (wr_en) begin
        next_addr_q <= next_addr_q + AW'(1);
      end
      if (wr_en) begin
        addr_q <= next_addr_q;
        for (int j = 0; j < COL; j++) begin
          data_q[j] <= aligned[j];
        end
      end
    end
  end

  // Column j needs COL-1-j stages; its first stage only loads inside its valid window.
  for (genvar j = 0; j < COL - 1; j++) begin : g_skew
    localparam int unsigned Depth = COL - 1 - j;
    logic [WIDTH-1:0] sr_q [Depth];
    logic             cap;

    assign cap = collect && ((cnt_q - CW'(j)) < CW'(n_q));

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        for (int s = 0; s < Depth; s++) begin
          sr_q[s] <= '0;
        end
      end else begin
        if (cap) begin
          sr_q[0] <= array_data_i[j];
        end
        for (int s = 1; s < Depth; s++) begin
          sr_q[s] <= sr_q[s-1];
        end
      end
    end

    assign aligned[j] = sr_q[Depth-1];
  end

  assign aligned[COL-1] = array_data_i[COL-1];

  assign ob_mem_we_o   = we_q;
  assign ob_mem_addr_o = addr_q;
  assign ob_mem_data_o = data_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StFin);

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector: one task per scenario, expected values
// written out by hand or from the element pattern the stimulus uses.
module tb_systolic_output_collector;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned COL   = 4;
  localparam int unsigned LAT   = 4;
  localparam int unsigned AW    = 8;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      start;
  logic [AW:0]               num_vec;
  logic [AW-1:0]             base;
  logic [COL-1:0][WIDTH-1:0] array_data;
  logic                      we;
  logic [AW-1:0]             addr;
  logic [COL-1:0][WIDTH-1:0] ob_data;
  logic                      busy;
  logic                      done;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_output_collector #(
    .WIDTH(WIDTH),
    .COL  (COL),
    .LAT  (LAT),
    .AW   (AW)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (start),
    .num_vec_i    (num_vec),
    .base_addr_i  (base),
    .array_data_i (array_data),
    .ob_mem_we_o  (we),
    .ob_mem_addr_o(addr),
    .ob_mem_data_o(ob_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] elem(int seed, int k, int j);
    return WIDTH'(seed + 16 * k + j);
  endfunction

  function automatic logic [COL*WIDTH-1:0] vec(int seed, int k);
    logic [COL-1:0][WIDTH-1:0] v;
    for (int j = 0; j < COL; j++) v[j] = elem(seed, k, j);
    return v;
  endfunction

  // Inputs for the edge that closes job-relative cycle c; 0xFF outside every window.
  task automatic drive(int c, int n, int seed, logic go, logic [AW-1:0] b);
    start   = go;
    num_vec = (AW+1)'(n);
    base    = b;
    for (int j = 0; j < COL; j++) begin
      automatic int k = c - int'(LAT) - j;
      array_data[j] = (k >= 0 && k < n) ? elem(seed, k, j) : 8'hFF;
    end
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    start      = 1'b0;
    num_vec    = '0;
    base       = '0;
    array_data = '1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({we, busy, done} !== 3'b000 || addr !== '0 || ob_data !== '0) begin
      n_fail++;
      $display("FAIL reset: we/busy/done=%b addr=%h data=%h, want all zero",
               {we, busy, done}, addr, ob_data);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [2:0] exp;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      drive(c, 1, 'hA0, c == 0, 8'h10);
      exp = {c == 8, c >= 1 && c <= 9, c == 9};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL single c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
      if (c == 8) begin
        n_tests++;
        if (addr !== 8'h10 || ob_data !== 32'hA3A2A1A0) begin
          n_fail++;
          $display("FAIL single write: addr=%h data=%h want 10 a3a2a1a0", addr, ob_data);
        end
      end
    end
  endtask

  task automatic test_multi();
    logic [2:0]  exp;
    logic [31:0] tbl [3];
    tbl = '{32'h03020100, 32'h13121110, 32'h23222120};
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      drive(c, 3, 0, c == 0, 8'h00);
      exp = {c >= 8 && c <= 10, c >= 1 && c <= 11, c == 11};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL multi c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
      if (c >= 8 && c <= 10) begin
        n_tests++;
        if (addr !== 8'(c - 8) || ob_data !== tbl[c-8]) begin
          n_fail++;
          $display("FAIL multi write c=%0d: addr=%h data=%h want %h %h",
                   c, addr, ob_data, 8'(c - 8), tbl[c-8]);
        end
      end
    end
  endtask

  task automatic test_zero();
    logic [2:0] exp;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(c, 0, 0, c == 0, 8'h55);
      exp = {1'b0, c == 1, c == 1};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL zero c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0]    exp;
    logic [AW-1:0] at [4];
    at = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      drive(c, 4, 'h40, c == 0, 8'hFE);
      exp = {c >= 8 && c <= 11, c >= 1 && c <= 12, c == 12};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL wrap c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
      if (c >= 8 && c <= 11) begin
        n_tests++;
        if (addr !== at[c-8] || ob_data !== vec('h40, c - 8)) begin
          n_fail++;
          $display("FAIL wrap write c=%0d: addr=%h data=%h want %h %h",
                   c, addr, ob_data, at[c-8], vec('h40, c - 8));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (c < 14) begin
        drive(c, 5, 'h10, c == 0, 8'h20);
        if (c == 6) begin
          // Retrigger while busy with different job parameters; must be ignored.
          start   = 1'b1;
          num_vec = 9'd2;
          base    = 8'h99;
        end
      end else begin
        drive(c - 14, 1, 'h70, c == 14, 8'h40);
      end
      exp = {(c >= 8 && c <= 12) || c == 22, (c >= 1 && c <= 13) || (c >= 15 && c <= 23),
             c == 13 || c == 23};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL b2b c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
      if (c >= 8 && c <= 12) begin
        n_tests++;
        if (addr !== 8'(8'h20 + c - 8) || ob_data !== vec('h10, c - 8)) begin
          n_fail++;
          $display("FAIL b2b write c=%0d: addr=%h data=%h want %h %h",
                   c, addr, ob_data, 8'(8'h20 + c - 8), vec('h10, c - 8));
        end
      end
      if (c == 22) begin
        n_tests++;
        if (addr !== 8'h40 || ob_data !== 32'h73727170) begin
          n_fail++;
          $display("FAIL b2b second job: addr=%h data=%h want 40 73727170", addr, ob_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(c, 4, 'h50, c == 0, 8'h30);
      exp = {c >= 8, c >= 1, 1'b0};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL rstmid c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({we, busy, done} !== 3'b000 || addr !== '0 || ob_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid async: we/busy/done=%b addr=%h data=%h want zero",
               {we, busy, done}, addr, ob_data);
    end
    start      = 1'b0;
    array_data = '1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests++;
      if ({we, busy, done} !== 3'b000 || addr !== '0 || ob_data !== '0) begin
        n_fail++;
        $display("FAIL rstmid after c=%0d: we/busy/done=%b addr=%h data=%h want zero",
                 c, {we, busy, done}, addr, ob_data);
      end
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(c, 1, 'h60, c == 0, 8'h77);
      exp = {c == 8, c >= 1 && c <= 9, c == 9};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL rstmid fresh c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
      if (c == 8) begin
        n_tests++;
        if (addr !== 8'h77 || ob_data !== 32'h63626160) begin
          n_fail++;
          $display("FAIL rstmid fresh write: addr=%h data=%h want 77 63626160", addr, ob_data);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [2:0] exp;
    for (int c = 0; c < 267; c++) begin
      @(negedge clk);
      drive(c, 256, 0, c == 0, 8'h05);
      exp = {c >= 8 && c <= 263, c >= 1 && c <= 264, c == 264};
      n_tests++;
      if ({we, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL full c=%0d we/busy/done=%b want %b", c, {we, busy, done}, exp);
      end
      if (c >= 8 && c <= 263) begin
        n_tests++;
        if (addr !== 8'(5 + c - 8) || ob_data !== vec(0, c - 8)) begin
          n_fail++;
          $display("FAIL full write c=%0d: addr=%h data=%h want %h %h",
                   c, addr, ob_data, 8'(5 + c - 8), vec(0, c - 8));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
